sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO. It is the same-clock-domain successor to the team's dual-clock FIFO and is used for buffering inside one clock domain. Over the earlier block it adds:
- an exact fill count
- run-time programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a synchronous flush
- a selectable first-word-fall-through (FWFT) read mode

---
 rtl/sync_fifo_prog.sv | 113 +++++++++++
 tb/tb_sync_fifo_prog.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with an exact fill count, run-time
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags, synchronous flush and an optional first-word-fall-through
// read port.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags are pure decodes of the registered count, so a threshold change
    // shows up in the same cycle while a push/pop shows up one cycle later.
    assign fifo_full         = (fill_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty        = (fill_count == '0);
    assign fifo_almost_full  = (fill_count >= af_thresh);
    assign fifo_almost_empty = (fill_count <= ae_thresh);

    // Flush wins over both requests; a full/empty FIFO rejects the request.
    assign wr_acc = wr_en && !fifo_full  && !flush;
    assign rd_acc = rd_en && !fifo_empty && !flush;

    // Storage array: written only on an accepted write, never reset or flushed.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, fill count and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   fill_count <= fill_count + 1'b1;
                2'b01:   fill_count <= fill_count - 1'b1;
                default: fill_count <= fill_count;
            endcase
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
            if (rd_en && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DATA_WIDTH-1:0] dout_q;

            // Registered read: word appears the cycle after an accepted read
            // and holds through idle cycles and rejected reads.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                end else if (flush) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end else begin : g_fwft_read
            // Head of queue is always presented; meaningful only when not empty.
            assign data_out = mem[rd_ptr];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read instance (depth 8) checked by a
// vector table plus a queue scoreboard, and an FWFT instance (depth 4)
// exercised by a short hand-written sequence.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Standard-read instance signals
    logic       flush0, wr0, rd0;
    logic [7:0] din0, dout0;
    logic [3:0] af0, ae0, cnt0;
    logic       full0, empty0, afull0, aempty0, ov0, un0;

    // FWFT instance signals
    logic       flush1, wr1, rd1;
    logic [7:0] din1, dout1;
    logic [2:0] af1, ae1, cnt1;
    logic       full1, empty1, afull1, aempty1, ov1, un1;

    sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .flush(flush0), .wr_en(wr0), .data_in(din0),
        .rd_en(rd0), .data_out(dout0), .af_thresh(af0), .ae_thresh(ae0),
        .fill_count(cnt0), .fifo_full(full0), .fifo_empty(empty0),
        .fifo_almost_full(afull0), .fifo_almost_empty(aempty0),
        .overflow(ov0), .underflow(un0)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(1)) dut_f (
        .clk(clk), .reset(reset), .flush(flush1), .wr_en(wr1), .data_in(din1),
        .rd_en(rd1), .data_out(dout1), .af_thresh(af1), .ae_thresh(ae1),
        .fill_count(cnt1), .fifo_full(full1), .fifo_empty(empty1),
        .fifo_almost_full(afull1), .fifo_almost_empty(aempty1),
        .overflow(ov1), .underflow(un1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard for the standard-read instance
    logic [7:0] sb_q[$];
    logic       m_ov, m_un;
    logic [7:0] m_dout;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         exp_cnt;
        logic       exp_full;
        logic       exp_af;
        logic       chk_d;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input int d, input int cnt,
                                input logic cd, input int ed);
        vec_t v;
        v.wr       = w;
        v.rd       = r;
        v.din      = 8'(d);
        v.exp_cnt  = cnt;
        v.exp_full = (cnt == 8);
        v.exp_af   = (cnt >= 6);
        v.chk_d    = cd;
        v.exp_d    = 8'(ed);
        return v;
    endfunction

    // One clock of the standard instance: drive at the falling edge, update
    // the scoreboard, then compare everything at the next falling edge.
    task automatic step0(input string tag, input logic w, input logic r, input logic f,
                         input logic [7:0] d);
        logic mfull, mempty;
        wr0 = w; rd0 = r; flush0 = f; din0 = d;
        if (f) begin
            sb_q.delete();
            m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;
        end else begin
            mfull  = (sb_q.size() == 8);
            mempty = (sb_q.size() == 0);
            if (w && mfull)  m_ov = 1'b1;
            if (r && mempty) m_un = 1'b1;
            if (r && !mempty) m_dout = sb_q.pop_front();
            if (w && !mfull)  sb_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        wr0 = 1'b0; rd0 = 1'b0; flush0 = 1'b0;
        chk({tag, ".count"},  32'(cnt0),   32'(sb_q.size()));
        chk({tag, ".empty"},  32'(empty0), 32'(sb_q.size() == 0));
        chk({tag, ".full"},   32'(full0),  32'(sb_q.size() == 8));
        chk({tag, ".aempty"}, 32'(aempty0), 32'(sb_q.size() <= int'(ae0)));
        chk({tag, ".ov"},     32'(ov0),    32'(m_ov));
        chk({tag, ".un"},     32'(un0),    32'(m_un));
        chk({tag, ".dout"},   32'(dout0),  32'(m_dout));
    endtask

    task automatic step1(input logic w, input logic r, input logic [7:0] d);
        wr1 = w; rd1 = r; din1 = d;
        @(posedge clk);
        @(negedge clk);
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    initial begin
        int k;
        // Vector table: fill, partial drain, wrap-around refill, full drain
        k = 0;
        for (int i = 0; i < 8; i++) begin tbl[k] = mk(1, 0, 8'h10 + i, i + 1, 0, 0); k++; end
        for (int i = 0; i < 4; i++) begin tbl[k] = mk(0, 1, 0, 7 - i, 1, 8'h10 + i); k++; end
        for (int i = 0; i < 4; i++) begin tbl[k] = mk(1, 0, 8'h18 + i, 5 + i, 0, 0); k++; end
        for (int i = 0; i < 8; i++) begin tbl[k] = mk(0, 1, 0, 7 - i, 1, 8'h14 + i); k++; end

        reset = 1'b1;
        flush0 = 0; wr0 = 0; rd0 = 0; din0 = 0; af0 = 4'd6; ae0 = 4'd1;
        flush1 = 0; wr1 = 0; rd1 = 0; din1 = 0; af1 = 3'd3; ae1 = 3'd0;
        m_ov = 0; m_un = 0; m_dout = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("init.empty", 32'(empty0), 32'd1);
        chk("init.afull", 32'(afull0), 32'd0);

        // 1. Asynchronous reset with three words stored and data_out nonzero
        for (int i = 0; i < 4; i++) step0("rst_wr", 1, 0, 0, 8'(8'h11 + i));
        step0("rst_rd", 0, 1, 0, 8'h00);
        reset = 1'b1;
        #1;
        chk("rst.count",  32'(cnt0),    32'd0);
        chk("rst.empty",  32'(empty0),  32'd1);
        chk("rst.aempty", 32'(aempty0), 32'd1);
        chk("rst.full",   32'(full0),   32'd0);
        chk("rst.dout",   32'(dout0),   32'd0);
        chk("rst.ov",     32'(ov0),     32'd0);
        sb_q.delete(); m_ov = 0; m_un = 0; m_dout = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 2. Fill and wrap, table-driven
        for (int i = 0; i < 24; i++) begin
            step0("tbl", tbl[i].wr, tbl[i].rd, 0, tbl[i].din);
            chk($sformatf("tbl%0d.count", i), 32'(cnt0),   32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d.full", i),  32'(full0),  32'(tbl[i].exp_full));
            chk($sformatf("tbl%0d.afull", i), 32'(afull0), 32'(tbl[i].exp_af));
            if (tbl[i].chk_d) chk($sformatf("tbl%0d.dout", i), 32'(dout0), 32'(tbl[i].exp_d));
        end
        chk("wrap.empty", 32'(empty0), 32'd1);

        // 3. Simultaneous operations
        for (int i = 0; i < 8; i++) step0("sim_fill", 1, 0, 0, 8'(8'h20 + i));
        step0("sim_full", 1, 1, 0, 8'h28);
        chk("simfull.count", 32'(cnt0), 32'd7);
        chk("simfull.ov",    32'(ov0),  32'd1);
        chk("simfull.dout",  32'(dout0), 32'h20);
        for (int i = 0; i < 3; i++) step0("sim_rd", 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step0("sim_half", 1, 1, 0, 8'(8'h30 + i));
            chk($sformatf("simhalf%0d.count", i), 32'(cnt0), 32'd4);
        end
        for (int i = 0; i < 4; i++) step0("sim_drain", 0, 1, 0, 8'h00);
        chk("simdrain.dout", 32'(dout0), 32'h34);
        step0("sim_empty", 1, 1, 0, 8'h40);
        chk("simempty.count", 32'(cnt0), 32'd1);
        chk("simempty.un",    32'(un0),  32'd1);
        chk("simempty.dout",  32'(dout0), 32'h34);

        // 4. Threshold changes take effect in the same cycle
        step0("thr_wr", 1, 0, 0, 8'h41);
        step0("thr_wr", 1, 0, 0, 8'h42);
        chk("thr.aempty_lo", 32'(aempty0), 32'd0);
        ae0 = 4'd3;
        #1;
        chk("thr.aempty_hi", 32'(aempty0), 32'd1);
        chk("thr.afull_lo",  32'(afull0),  32'd0);
        af0 = 4'd3;
        #1;
        chk("thr.afull_hi",  32'(afull0),  32'd1);
        @(negedge clk);
        af0 = 4'd6; ae0 = 4'd1;

        // 5. Flush beats simultaneous write and read
        step0("fl_wr", 1, 0, 0, 8'h43);
        step0("fl_wr", 1, 0, 0, 8'h44);
        chk("pre_fl.count", 32'(cnt0), 32'd5);
        chk("pre_fl.ov",    32'(ov0),  32'd1);
        chk("pre_fl.un",    32'(un0),  32'd1);
        step0("flush", 1, 1, 1, 8'h99);
        chk("fl.count", 32'(cnt0), 32'd0);
        chk("fl.ov",    32'(ov0),  32'd0);
        chk("fl.un",    32'(un0),  32'd0);
        chk("fl.dout",  32'(dout0), 32'd0);
        step0("post_fl_wr", 1, 0, 0, 8'hAA);
        step0("post_fl_rd", 0, 1, 0, 8'h00);
        chk("postfl.dout", 32'(dout0), 32'hAA);

        // 6. FWFT instance
        chk("fw.init_empty", 32'(empty1), 32'd1);
        step1(1, 0, 8'h5A);
        chk("fw.empty_after_wr", 32'(empty1), 32'd0);
        chk("fw.head",           32'(dout1),  32'h5A);
        step1(1, 0, 8'h5B);
        chk("fw.head_hold", 32'(dout1), 32'h5A);
        chk("fw.count2",    32'(cnt1),  32'd2);
        step1(0, 1, 8'h00);
        chk("fw.pop1_dout",  32'(dout1), 32'h5B);
        chk("fw.pop1_count", 32'(cnt1),  32'd1);
        step1(0, 1, 8'h00);
        chk("fw.pop2_empty", 32'(empty1), 32'd1);
        chk("fw.un_before",  32'(un1),    32'd0);
        step1(0, 1, 8'h00);
        chk("fw.underflow",  32'(un1),    32'd1);
        chk("fw.count0",     32'(cnt1),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
